// File: rtl/ddr_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  ddr_port_arbiter_pkg
//  Shared DDR port types and default arbiter configuration.
//  Revision: 1.0
// ============================================================================
package ddr_port_arbiter_pkg;

    localparam int c_ddr_addr_w         = 32;
    localparam int c_ddr_data_w         = 32;
    localparam int c_ddr_timeout_cycles = 1024;

    typedef logic [c_ddr_addr_w-1:0] ddr_address_t;
    typedef logic [c_ddr_data_w-1:0] ddr_data_t;

    typedef struct packed {
        ddr_address_t addr;
        ddr_data_t    data;
        logic         write;
    } ddr_req_t;

endpackage
`default_nettype wire

// File: rtl/ddr_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  ddr_port_arbiter_rr_pick
//  Combinational round-robin pick: first pending index after the pointer.
//  Revision: 1.0
// ============================================================================
module ddr_port_arbiter_rr_pick #(
    parameter int NUM_REQUESTERS = 2,
    parameter int IDX_W          = 1
) (
    input  logic [NUM_REQUESTERS-1:0] pending_i,
    input  logic [IDX_W-1:0]          pointer_i,
    output logic [IDX_W-1:0]          grant_o,
    output logic                      any_o
);

    logic [IDX_W-1:0] w_idx;

    assign any_o = |pending_i;

    // Scan farthest-first so the nearest pending index after the pointer wins.
    always_comb begin
        grant_o = '0;
        w_idx   = '0;
        for (int k = NUM_REQUESTERS; k >= 1; k--) begin
            w_idx = IDX_W'((int'(pointer_i) + k) % NUM_REQUESTERS);
            if (pending_i[w_idx]) begin
                grant_o = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  ddr_port_arbiter
//  Round-robin sharing of one DDR port, one buffered request per client and
//  a single outstanding DDR transaction.
//  Revision: 1.0
// ============================================================================
module ddr_port_arbiter
    import ddr_port_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int TIMEOUT_CYCLES = c_ddr_timeout_cycles
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQUESTERS-1:0]          req_r_en_i,
    input  logic [NUM_REQUESTERS-1:0]          req_w_en_i,
    input  ddr_address_t [NUM_REQUESTERS-1:0]  req_address_i,
    input  ddr_data_t [NUM_REQUESTERS-1:0]     req_w_data_i,
    output logic [NUM_REQUESTERS-1:0]          req_ready_o,
    output ddr_data_t                          rsp_r_data_o,
    output logic [NUM_REQUESTERS-1:0]          rsp_r_valid_o,
    output logic [NUM_REQUESTERS-1:0]          rsp_w_done_o,
    output logic                               ddr_r_en_o,
    output logic                               ddr_w_en_o,
    output ddr_address_t                       ddr_address_o,
    output ddr_data_t                          ddr_w_data_o,
    input  ddr_data_t                          ddr_r_data_i,
    input  logic                               ddr_r_valid_i,
    input  logic                               ddr_w_done_i,
    output logic                               timeout_o,
    output logic                               spurious_o
);

    localparam int c_idx_w = $clog2(NUM_REQUESTERS);
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [NUM_REQUESTERS-1:0] r_pend;
    ddr_req_t [NUM_REQUESTERS-1:0] r_slot;
    logic [c_idx_w-1:0]        r_ptr;
    logic [c_idx_w-1:0]        r_grant;
    logic                      r_op_write;
    ddr_address_t              r_addr;
    ddr_data_t                 r_data;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [NUM_REQUESTERS-1:0] r_rsp_rvalid;
    logic [NUM_REQUESTERS-1:0] r_rsp_wdone;
    ddr_data_t                 r_rsp_data;
    logic                      r_timeout;
    logic                      r_spurious;

    logic [c_idx_w-1:0]        w_pick;
    logic                      w_any;
    logic                      w_load;
    logic                      w_done;
    logic                      w_expire;
    logic                      w_match;
    logic                      w_spur;
    logic [NUM_REQUESTERS-1:0] w_release;

    ddr_port_arbiter_rr_pick #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .IDX_W          (c_idx_w)
    ) u_rr_pick (
        .pending_i (r_pend),
        .pointer_i (r_ptr),
        .grant_o   (w_pick),
        .any_o     (w_any)
    );

    // Pulses arriving while a slot is occupied are dropped; r+w together acts as a write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend <= '0;
            r_slot <= '0;
        end else begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (w_release[i]) begin
                    r_pend[i] <= 1'b0;
                end else if (!r_pend[i] && (req_r_en_i[i] || req_w_en_i[i])) begin
                    r_pend[i]       <= 1'b1;
                    r_slot[i].addr  <= req_address_i[i];
                    r_slot[i].data  <= req_w_data_i[i];
                    r_slot[i].write <= req_w_en_i[i];
                end
            end
        end
    end

    assign w_match = r_op_write ? ddr_w_done_i : ddr_r_valid_i;
    assign w_spur  = (r_state != c_st_wait) ? (ddr_r_valid_i | ddr_w_done_i)
                                            : (r_op_write ? ddr_r_valid_i : ddr_w_done_i);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_expire    = 1'b0;
        w_release   = '0;
        case (r_state)
            c_st_idle: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_issue: begin
                w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
                // A completion landing on the last counted cycle still wins.
                if (w_match) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_st_idle;
                end else if (r_cnt == c_cnt_last) begin
                    w_expire    = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        w_release[r_grant] = w_done | w_expire;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= c_st_idle;
            r_ptr        <= c_idx_w'(NUM_REQUESTERS - 1);
            r_grant      <= '0;
            r_op_write   <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_cnt        <= '0;
            r_rsp_rvalid <= '0;
            r_rsp_wdone  <= '0;
            r_rsp_data   <= '0;
            r_timeout    <= 1'b0;
            r_spurious   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rsp_rvalid <= '0;
            r_rsp_wdone  <= '0;
            if (w_load) begin
                r_grant    <= w_pick;
                r_ptr      <= w_pick;
                r_op_write <= r_slot[w_pick].write;
                r_addr     <= r_slot[w_pick].addr;
                r_data     <= r_slot[w_pick].data;
            end
            if (r_state == c_st_issue) begin
                r_cnt <= '0;
            end else if (r_state == c_st_wait) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done) begin
                if (r_op_write) begin
                    r_rsp_wdone[r_grant] <= 1'b1;
                end else begin
                    r_rsp_rvalid[r_grant] <= 1'b1;
                    r_rsp_data            <= ddr_r_data_i;
                end
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
            if (w_spur) begin
                r_spurious <= 1'b1;
            end
        end
    end

    assign req_ready_o   = ~r_pend;
    assign rsp_r_data_o  = r_rsp_data;
    assign rsp_r_valid_o = r_rsp_rvalid;
    assign rsp_w_done_o  = r_rsp_wdone;
    assign ddr_r_en_o    = (r_state == c_st_issue) && !r_op_write;
    assign ddr_w_en_o    = (r_state == c_st_issue) && r_op_write;
    assign ddr_address_o = r_addr;
    assign ddr_w_data_o  = r_data;
    assign timeout_o     = r_timeout;
    assign spurious_o    = r_spurious;

endmodule
`default_nettype wire
